// File: rtl/rf_wb_if.sv
// Write-port bundle between the writeback requesters (A, B), the issue/decode
// side and the register file.
interface rf_wb_if;
    // Handshake: a requester raises *_valid with *_rd/*_wd and holds all three
    // stable until it samples *_ready=1; the write is taken at the posedge on
    // which valid & ready are both high.
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_wd;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_wd;
    logic        b_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        rf_we_n;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        init_done;

    modport master (
        output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, iss_valid, iss_rd, rs1, rs2,
        input  a_ready, b_ready, hazard, rf_we_n, rf_rd, rf_wd, init_done
    );

    modport slave (
        input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd, iss_valid, iss_rd, rs1, rs2,
        output a_ready, b_ready, hazard, rf_we_n, rf_rd, rf_wd, init_done
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with starvation-bounded priority and a
// pending-B scoreboard. Define RF_INIT_CLEAR_EN to build the x1..x31 clear sweep.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  bus,
    output logic    state_dbg
);
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    state_t      state;
    logic        run;
    logic [3:0]  starve_cnt;
    logic [31:0] busy;
    logic [31:0] busy_nxt;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        a_req, b_req, a_x0, b_x0;
    logic        conflict, starved, grant_a, grant_b;

`ifdef RF_INIT_CLEAR_EN
    state_t      state_nxt;
    logic [4:0]  idx;
    logic [4:0]  idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            idx   <= 5'd1;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == S_INIT) begin
            idx_nxt = idx + 5'd1;
            if (idx == 5'd31) state_nxt = S_RUN;
        end
    end
`else
    assign state = S_RUN;
`endif

    assign state_dbg = (state == S_RUN);
    assign run       = (state == S_RUN) && !rst;

    // x0 requests complete without touching the port, so they never conflict.
    assign a_x0     = bus.a_valid && (bus.a_rd == 5'd0);
    assign b_x0     = bus.b_valid && (bus.b_rd == 5'd0);
    assign a_req    = bus.a_valid && (bus.a_rd != 5'd0);
    assign b_req    = bus.b_valid && (bus.b_rd != 5'd0);
    assign conflict = a_req && b_req;
    assign starved  = (starve_cnt >= 4'(STARVE_LIMIT));
    assign grant_a  = run && a_req && (!b_req || starved);
    assign grant_b  = run && b_req && !grant_a;

    always_comb begin
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        bus.rf_we_n = 1'b1;
        bus.rf_rd   = 5'd0;
        bus.rf_wd   = 32'd0;
        if (run) begin
            bus.a_ready = a_x0 || grant_a;
            bus.b_ready = b_x0 || grant_b;
            if (grant_a) begin
                bus.rf_we_n = 1'b0;
                bus.rf_rd   = bus.a_rd;
                bus.rf_wd   = bus.a_wd;
            end else if (grant_b) begin
                bus.rf_we_n = 1'b0;
                bus.rf_rd   = bus.b_rd;
                bus.rf_wd   = bus.b_wd;
            end
        end
`ifdef RF_INIT_CLEAR_EN
        if (!rst && state == S_INIT) begin
            bus.rf_we_n = 1'b0;
            bus.rf_rd   = idx;
        end
`endif
    end

    // Issue wins over a same-cycle clear: the new operation owns the register.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (bus.iss_valid && bus.iss_rd != 5'd0) set_mask = 32'd1 << bus.iss_rd;
        if (grant_b) clr_mask = 32'd1 << bus.b_rd;
        busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            busy       <= 32'd0;
        end else if (state == S_RUN) begin
            if (grant_a)
                starve_cnt <= 4'd0;
            else if (conflict && starve_cnt != 4'hf)
                starve_cnt <= starve_cnt + 4'd1;
            busy <= busy_nxt;
        end
    end

    assign bus.hazard    = run && (((bus.rs1 != 5'd0) && busy[bus.rs1]) ||
                                   ((bus.rs2 != 5'd0) && busy[bus.rs2]));
    assign bus.init_done = run;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a cycle-level reference model queues the
// expected port writes and control outputs; a negedge monitor compares them.
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;
`ifdef RF_INIT_CLEAR_EN
  localparam int INIT_CYC = 31;
`else
  localparam int INIT_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic state_dbg;
  int   checks = 0;
  int   errors = 0;

  rf_wb_if bus();

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // reference model state
  bit  busy_m[32];
  int  losses;
  int  init_idx;

  // scoreboard queues
  logic [36:0] exp_q[$];   // {rd, wd} of each expected port write
  logic [4:0]  ctl_q[$];   // {we_n, a_ready, b_ready, hazard, init_done}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    losses   = 0;
    init_idx = (INIT_CYC != 0) ? 1 : 0;
  endtask

  // driver: called just after a posedge, drives one cycle and returns after the next posedge
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bwd,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2,
                      output logic ea, output logic eb);
    logic a_real, b_real, a_win, b_win, hz, done, wr;
    bus.a_valid = av; bus.a_rd = ard; bus.a_wd = awd;
    bus.b_valid = bv; bus.b_rd = brd; bus.b_wd = bwd;
    bus.iss_valid = iv; bus.iss_rd = ird;
    bus.rs1 = r1; bus.rs2 = r2;
    ea = 1'b0; eb = 1'b0; hz = 1'b0; done = 1'b0; wr = 1'b0;
    if (init_idx != 0) begin
      wr = 1'b1;
      exp_q.push_back({5'(init_idx), 32'd0});
      init_idx = (init_idx == 31) ? 0 : init_idx + 1;
    end else begin
      a_real = av && (ard != 0);
      b_real = bv && (brd != 0);
      a_win  = a_real && (!b_real || losses >= LIMIT);
      b_win  = b_real && !a_win;
      ea     = av && (ard == 0 || a_win);
      eb     = bv && (brd == 0 || b_win);
      hz     = (r1 != 0 && busy_m[r1]) || (r2 != 0 && busy_m[r2]);
      done   = 1'b1;
      if (a_win) begin wr = 1'b1; exp_q.push_back({ard, awd}); end
      else if (b_win) begin wr = 1'b1; exp_q.push_back({brd, bwd}); end
      if (a_win) losses = 0;
      else if (a_real && b_real) losses++;
      if (b_win) busy_m[brd] = 1'b0;
      if (iv && ird != 0) busy_m[ird] = 1'b1;
    end
    ctl_q.push_back({!wr, ea, eb, hz, done});
    @(posedge clk); #1;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [4:0]  c;
    logic [36:0] w;
    if (ctl_q.size() > 0) begin
      c = ctl_q.pop_front();
      chk("rf_we_n",   64'(bus.rf_we_n),   64'(c[4]));
      chk("a_ready",   64'(bus.a_ready),   64'(c[3]));
      chk("b_ready",   64'(bus.b_ready),   64'(c[2]));
      chk("hazard",    64'(bus.hazard),    64'(c[1]));
      chk("init_done", 64'(bus.init_done), 64'(c[0]));
    end
    if (!bus.rf_we_n) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got rd %0d wd %0h expected no write", bus.rf_rd, bus.rf_wd);
      end else begin
        w = exp_q.pop_front();
        chk("rf_rd", 64'(bus.rf_rd), 64'(w[36:32]));
        chk("rf_wd", 64'(bus.rf_wd), 64'(w[31:0]));
      end
    end else begin
      chk("idle_rf_bus", {27'd0, bus.rf_rd, bus.rf_wd}, 64'd0);
    end
  end

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_wd = 32'd0;
    bus.b_valid = 1'b0; bus.b_rd = 5'd0; bus.b_wd = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic ea, eb;
    logic pa, pb;
    logic [4:0]  par, pbr;
    logic [31:0] paw, pbw;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we_n", 64'(bus.rf_we_n), 64'd1);
    chk("reset_init_done", 64'(bus.init_done), 64'd0);
    release_reset();

    // INIT sweep (if built) with A and B waiting; B rd 4 granted first in RUN
    repeat (INIT_CYC + 1) step(1'b1, 5'd2, 32'h2222_0000, 1'b1, 5'd4, 32'h4444_0000,
                                1'b0, 5'd0, 5'd0, 5'd0, ea, eb);

    // continuous conflict: B x LIMIT then A, repeating
    repeat (15) step(1'b1, 5'd5, 32'hA5A5_0005, 1'b1, 5'd6, 32'hB6B6_0006,
                     1'b0, 5'd0, 5'd0, 5'd0, ea, eb);

    // x0 write alongside a B write
    step(1'b1, 5'd0, 32'hDEAD_0000, 1'b1, 5'd7, 32'h0000_0007, 1'b0, 5'd0, 5'd0, 5'd0, ea, eb);

    // scoreboard set, clear, and same-cycle issue+clear
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, ea, eb);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, ea, eb);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 5'd9, 5'd0, ea, eb);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, ea, eb);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd9, ea, eb);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, ea, eb);
    step(1'b1, 5'd9, 32'h19, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, ea, eb);

    // randomized traffic; a request is held until accepted
    pa = 1'b0; pb = 1'b0; par = 5'd0; pbr = 5'd0; paw = 32'd0; pbw = 32'd0;
    repeat (400) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1; par = 5'($urandom_range(0, 11)); paw = $urandom;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1'b1; pbr = 5'($urandom_range(0, 11)); pbw = $urandom;
      end
      step(pa, par, paw, pb, pbr, pbw, 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 11)),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), ea, eb);
      if (ea) pa = 1'b0;
      if (eb) pb = 1'b0;
    end

    // reset mid-conflict with x3 pending
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0, ea, eb);
    step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd3, 5'd0, ea, eb);
    bus.rs1 = 5'd3;
    #1 rst = 1'b1;
    #1;
    chk("midrst_we_n",      64'(bus.rf_we_n),   64'd1);
    chk("midrst_a_ready",   64'(bus.a_ready),   64'd0);
    chk("midrst_b_ready",   64'(bus.b_ready),   64'd0);
    chk("midrst_hazard",    64'(bus.hazard),    64'd0);
    chk("midrst_init_done", 64'(bus.init_done), 64'd0);
    release_reset();
    repeat (INIT_CYC + 6) step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66,
                               1'b0, 5'd0, 5'd3, 5'd0, ea, eb);

    idle_inputs();
    repeat (2) @(posedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("ctl_q_drained", 64'(ctl_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the core's 32×32 register file. It shares the file's single active-low write port between two requesters: A, the single-cycle ALU writeback, and B, the long-latency load/multiply-divide writeback. Arbitration uses a starvation-bounded priority. A 31-entry scoreboard tracks registers with an outstanding B result and raises a read hazard. An optional post-reset sequencer clears x1–x31. The block sits between the execute/writeback logic and the register file.

## Interface
- STARVE_LIMIT, 4, consecutive conflict cycles A may lose before it is granted; valid range 1–15.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  A has a write.
- a_rd  in  5  A destination register.
- a_wd  in  32  A write data.
- a_ready  out  1  A write accepted this cycle.
- b_valid  in  1  B has a write.
- b_rd  in  5  B destination register.
- b_wd  in  32  B write data.
- b_ready  out  1  B write accepted this cycle.
- iss_valid  in  1  a B operation is issued this cycle.
- iss_rd  in  5  destination register of the issued B operation.
- rs1  in  5  read index under hazard check.
- rs2  in  5  read index under hazard check.
- hazard  out  1  rs1 or rs2 has a pending B result.
- rf_we_n  out  1  register file write enable, active-low.
- rf_rd  out  5  register file write index.
- rf_wd  out  32  register file write data.
- init_done  out  1  block is in RUN; requesters may be served.

## Operation
- State machine:
  - INIT: present only when the clear macro is compiled in.
  - RUN: normal operation.
  - Reset enters INIT if compiled in, otherwise RUN.
- INIT:
  - 5-bit index idx starts at 1.
  - Each cycle drives rf_we_n=0, rf_rd=idx, rf_wd=0, then idx increments.
  - After the idx=31 write, transitions to RUN.
  - Throughout INIT: a_ready=b_ready=0, iss_valid is ignored, hazard=0.
- RUN arbitration (combinational):
  - Only A valid: A granted.
  - Only B valid: B granted.
  - Both valid: B granted, unless starve_cnt ≥ STARVE_LIMIT, in which case A is granted.
  - The granted requester gets ready=1 and drives rf_rd/rf_wd with rf_we_n=0.
  - The loser gets ready=0 and must hold its request stable.
  - With no grant: rf_we_n=1, rf_rd=0, rf_wd=0.
- x0 writes:
  - A request with rd=0 gets ready=1 immediately, regardless of conflict.
  - It does not consume the port; the other requester may be granted in the same cycle.
  - It never asserts rf_we_n.
- starve_cnt (4-bit, saturating):
  - Increments on each cycle where A and B are both valid with nonzero rd and A loses.
  - Clears whenever A is granted.
- Scoreboard busy[31:1]:
  - Set at posedge on iss_valid with iss_rd≠0.
  - Cleared at posedge on a B handshake (b_valid&b_ready) for b_rd.
  - Issue and clear to the same rd in the same cycle: set wins.
  - An A write to a busy rd is performed; busy is unchanged.
- hazard = (rs1≠0 & busy[rs1]) | (rs2≠0 & busy[rs2]).
- rst asserted (including mid-INIT or mid-RUN):
  - Immediately: rf_we_n=1, a_ready=b_ready=0, hazard=0, init_done=0.
  - busy cleared, starve_cnt=0, idx=1.
  - INIT restarts after release.

## Timing
- Grant, ready and rf_* outputs are combinational: zero-cycle latency; the write lands on the next posedge.
- Scoreboard set/clear are visible on hazard the cycle after the issue or handshake edge.
- INIT lasts exactly 31 cycles after rst release; init_done=1 from the 32nd cycle onward.
- With STARVE_LIMIT=N and continuous conflict:
  - B is granted N consecutive times, then A once.
  - The pattern repeats.

## Configuration
- RF_INIT_CLEAR_EN:
  - Defined: the INIT sweep is built; init_done behaves as above.
  - Undefined: the INIT state and idx are removed; reset enters RUN directly; init_done is tied to 1 except while rst is asserted (then 0); register contents after reset are undefined.

## Test plan
- Reset release with RF_INIT_CLEAR_EN: rf_we_n=0 for 31 cycles, rf_rd sweeping 1..31, rf_wd=0 → init_done rises in cycle 32; a_valid during INIT sees a_ready=0.
- Both valid continuously (a_rd=5, b_rd=6, STARVE_LIMIT=4) → grants B,B,B,B,A repeating; every write lands on the next edge.
- a_valid with a_rd=0 while B is valid with b_rd=7 → a_ready=1 and b_ready=1 in the same cycle; rf_rd=7.
- iss_valid with iss_rd=9; next cycle rs1=9 → hazard=1; B writes rd 9 → hazard=0 the following cycle; issue and clear of rd 9 in the same cycle → hazard stays 1.
- rst pulsed mid-conflict with busy[3]=1 → all ready=0, rf_we_n=1 immediately; after release, busy=0, starve_cnt=0, INIT re-runs.
- Build without RF_INIT_CLEAR_EN → init_done=1 in the first cycle after release; b_valid with b_rd=4 is granted in that cycle.
